// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared encodings for the program-counter stage and the multicycle control
// FSM that drives it.
//   PCWE_*  : pc_we write-enable codes
//   PCSRC_* : pc_src next-PC source select codes
//   branch_offset() : turns a BEQ immediate into a byte offset
// ---------------------------------------------------------------------------
package pc_pkg;

  localparam logic [1:0] PCWE_HOLD   = 2'd0;
  localparam logic [1:0] PCWE_UNCOND = 2'd1;
  localparam logic [1:0] PCWE_COND   = 2'd2;
  localparam logic [1:0] PCWE_RSVD   = 2'd3;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JR  = 2'd2;
  localparam logic [1:0] PCSRC_J   = 2'd3;

  // Sign-extend the 16-bit word offset and scale it to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// ---------------------------------------------------------------------------
// pc_next_calc
// Purely combinational next-PC candidate generator and selector.
// Ports:
//   pc         in  32  current architectural PC (already PC+4 after IF)
//   ir         in  32  instruction register
//   rs_data    in  32  register-file rs value, JR target
//   pc_src     in   2  source select (PCSRC_* codes)
//   target     out 32  selected next-PC candidate
//   misaligned out  1  selected target is not word aligned
// ---------------------------------------------------------------------------
module pc_next_calc
  import pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] rs_data,
  input  logic [1:0]  pc_src,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] seq_target;
  logic [31:0] br_target;
  logic [31:0] j_target;

  // The opcode field never influences the target; only the immediate and
  // jump-index fields are consumed here.
  logic unused_opcode;
  assign unused_opcode = ^ir[31:26];

  // Carry out of bit 31 is dropped, so PC wrap from FFFF_FFFC to 0 is legal.
  assign seq_target = pc + 32'd4;
  assign br_target  = pc + branch_offset(ir[15:0]);
  assign j_target   = {pc[31:28], ir[25:0], 2'b00};

  always_comb begin
    target = seq_target;
    unique case (pc_src)
      PCSRC_SEQ: target = seq_target;
      PCSRC_BR:  target = br_target;
      PCSRC_JR:  target = rs_data;
      PCSRC_J:   target = j_target;
      default:   target = seq_target;
    endcase
  end

  // Only a JR can realistically land here; the other candidates are built
  // from an aligned pc plus a multiple of four.
  assign misaligned = (target[1:0] != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program-counter stage downstream of the multicycle control FSM. Holds the
// architectural PC, the retired-instruction counter and a sticky error flag.
// Parameters:
//   RESET_PC  PC value loaded on reset
//   CNT_W     width of the instruction / branch counters
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   pc_we        in   2      write enable code (PCWE_*)
//   pc_src       in   2      next-PC source (PCSRC_*)
//   ir           in   32     instruction register
//   rs_data      in   32     rs read value for JR
//   alu_zero     in   1      BEQ compare result
//   pc           out  32     registered PC, instruction-memory address
//   link         out  32     JAL link value (combinational copy of pc)
//   instret      out  CNT_W  instruction-fetch counter
//   pc_err       out  1      sticky misalignment / reserved-code flag
// Optional (macro PC_UNIT_BRANCH_STATS_EN):
//   br_taken     out  CNT_W  conditional writes with alu_zero=1
//   br_not_taken out  CNT_W  conditional writes with alu_zero=0
// ---------------------------------------------------------------------------
module pc_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pc_we,
  input  logic [1:0]       pc_src,
  input  logic [31:0]      ir,
  input  logic [31:0]      rs_data,
  input  logic             alu_zero,
  output logic [31:0]      pc,
  output logic [31:0]      link,
  output logic [CNT_W-1:0] instret,
  output logic             pc_err
`ifdef PC_UNIT_BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0] br_taken,
  output logic [CNT_W-1:0] br_not_taken
`endif
);

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             err_q, err_d;
  logic [31:0]      target;
  logic             misaligned;
  logic             write_en;

  pc_next_calc u_next_calc (
    .pc         (pc_q),
    .ir         (ir),
    .rs_data    (rs_data),
    .pc_src     (pc_src),
    .target     (target),
    .misaligned (misaligned)
  );

  // An unknown alu_zero falls into the else branch of the if below and is
  // therefore treated as not-taken; flag it in simulation anyway.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (pc_we == PCWE_COND) |-> !$isunknown(alu_zero))
    else $error("pc_unit: alu_zero unknown during conditional PC write");

  always_comb begin
    write_en = 1'b0;
    if (pc_we == PCWE_UNCOND) begin
      write_en = 1'b1;
    end else if (pc_we == PCWE_COND) begin
      if (alu_zero) write_en = 1'b1;
    end
  end

  // A misaligned target suppresses the write but still flags the error.
  // Once the flag is up, later writes continue normally.
  always_comb begin
    pc_d      = pc_q;
    err_d     = err_q;
    instret_d = instret_q;
    if (write_en && !misaligned) pc_d = target;
    if (write_en && misaligned) err_d = 1'b1;
    if (pc_we == PCWE_RSVD) err_d = 1'b1;
    // The IF state is the only pc_we=1/pc_src=0 combination, so this counts
    // fetches; the count wraps silently.
    if (pc_we == PCWE_UNCOND && pc_src == PCSRC_SEQ)
      instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      err_q     <= 1'b0;
      instret_q <= '0;
    end else begin
      pc_q      <= pc_d;
      err_q     <= err_d;
      instret_q <= instret_d;
    end
  end

`ifdef PC_UNIT_BRANCH_STATS_EN
  logic [CNT_W-1:0] br_taken_q, br_taken_d;
  logic [CNT_W-1:0] br_not_taken_q, br_not_taken_d;

  always_comb begin
    br_taken_d     = br_taken_q;
    br_not_taken_d = br_not_taken_q;
    if (pc_we == PCWE_COND) begin
      if (alu_zero) br_taken_d = br_taken_q + CNT_W'(1);
      else          br_not_taken_d = br_not_taken_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_q     <= '0;
      br_not_taken_q <= '0;
    end else begin
      br_taken_q     <= br_taken_d;
      br_not_taken_q <= br_not_taken_d;
    end
  end

  assign br_taken     = br_taken_q;
  assign br_not_taken = br_not_taken_q;
`endif

  assign pc      = pc_q;
  assign link    = pc_q;
  assign instret = instret_q;
  assign pc_err  = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Scoreboard bench for pc_unit. The stimulus side drives one directed vector
// per cycle and queues the hand-computed post-edge state; a monitor pops and
// compares on each falling edge. A second instance with a 4-bit counter
// shares all inputs so counter wrap is reachable in a few cycles.
// ---------------------------------------------------------------------------
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [1:0]  pcWe;
  logic [1:0]  pcSrc;
  logic [31:0] ir;
  logic [31:0] rsData;
  logic        aluZero;

  logic [31:0] pcOut, linkOut;
  logic [31:0] instretOut;
  logic        errOut;
  logic [31:0] pcSmall, linkSmall;
  logic [3:0]  instretSmall;
  logic        errSmall;
`ifdef PC_UNIT_BRANCH_STATS_EN
  logic [31:0] brTaken, brNotTaken;
  logic [3:0]  brTakenSmall, brNotTakenSmall;
`endif

  pc_unit #(.RESET_PC(32'h0000_1000), .CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_we    (pcWe),
    .pc_src   (pcSrc),
    .ir       (ir),
    .rs_data  (rsData),
    .alu_zero (aluZero),
    .pc       (pcOut),
    .link     (linkOut),
    .instret  (instretOut),
    .pc_err   (errOut)
`ifdef PC_UNIT_BRANCH_STATS_EN
    ,
    .br_taken     (brTaken),
    .br_not_taken (brNotTaken)
`endif
  );

  pc_unit #(.RESET_PC(32'h0000_1000), .CNT_W(4)) dutSmall (
    .clk      (clk),
    .rst_n    (rst_n),
    .pc_we    (pcWe),
    .pc_src   (pcSrc),
    .ir       (ir),
    .rs_data  (rsData),
    .alu_zero (aluZero),
    .pc       (pcSmall),
    .link     (linkSmall),
    .instret  (instretSmall),
    .pc_err   (errSmall)
`ifdef PC_UNIT_BRANCH_STATS_EN
    ,
    .br_taken     (brTakenSmall),
    .br_not_taken (brNotTakenSmall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        err;
  } expT;

  expT         sb[$];
  expT         monEntry;
  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] expInstret = 0;
  bit          stimDone   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    else
      passCount++;
  endtask

  // Monitor: everything queued since the last falling edge is compared now.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        monEntry = sb.pop_front();
        checkOutput({monEntry.name, ".pc"}, pcOut, monEntry.pc);
        checkOutput({monEntry.name, ".link"}, linkOut, monEntry.pc);
        checkOutput({monEntry.name, ".instret"}, instretOut, monEntry.instret);
        checkOutput({monEntry.name, ".err"}, {31'b0, errOut}, {31'b0, monEntry.err});
        checkOutput({monEntry.name, ".pcSmall"}, pcSmall, monEntry.pc);
        checkOutput({monEntry.name, ".instretSmall"}, {28'b0, instretSmall},
                    {28'b0, monEntry.instret[3:0]});
      end
    end
  end

  task automatic pushExp(input string name, input logic [31:0] expPc,
                         input logic expErr);
    expT e;
    e.name    = name;
    e.pc      = expPc;
    e.instret = expInstret;
    e.err     = expErr;
    sb.push_back(e);
  endtask

  // One vector: drive on the falling edge, let one rising edge act, queue
  // the expected result, then return the write enable to hold.
  task automatic applyStimulus(input string name, input logic [1:0] we,
                               input logic [1:0] src, input logic [31:0] irVal,
                               input logic [31:0] rsVal, input logic zero,
                               input logic [31:0] expPc, input logic expErr);
    @(negedge clk);
    pcWe    = we;
    pcSrc   = src;
    ir      = irVal;
    rsData  = rsVal;
    aluZero = zero;
    @(posedge clk);
    if (we == PCWE_UNCOND && src == PCSRC_SEQ) expInstret = expInstret + 1;
    pushExp(name, expPc, expErr);
    #1 pcWe = PCWE_HOLD;
  endtask

  // Reset asserted between edges, with a fetch write pending at the next
  // edge; the first check lands before any rising edge.
  task automatic midReset(input string name);
    @(posedge clk);
    #2;
    pcWe  = PCWE_UNCOND;
    pcSrc = PCSRC_SEQ;
    rst_n = 1'b0;
    expInstret = 0;
    pushExp({name, "_async"}, 32'h0000_1000, 1'b0);
    @(posedge clk);
    #1;
    pushExp({name, "_held"}, 32'h0000_1000, 1'b0);
    pcWe = PCWE_HOLD;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    pcWe    = PCWE_HOLD;
    pcSrc   = PCSRC_SEQ;
    ir      = 32'h0;
    rsData  = 32'h0;
    aluZero = 1'b0;
    repeat (2) @(posedge clk);
    #2 pushExp("reset", 32'h0000_1000, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    applyStimulus("if1",      PCWE_UNCOND, PCSRC_SEQ, 32'h0,         32'h0,         1'b0, 32'h0000_1004, 1'b0);
    applyStimulus("j2000",    PCWE_UNCOND, PCSRC_J,   32'h0800_0800, 32'h0,         1'b0, 32'h0000_2000, 1'b0);
    applyStimulus("if2",      PCWE_UNCOND, PCSRC_SEQ, 32'h0,         32'h0,         1'b0, 32'h0000_2004, 1'b0);
    applyStimulus("beqNt",    PCWE_COND,   PCSRC_BR,  32'h1000_FFFE, 32'h0,         1'b0, 32'h0000_2004, 1'b0);
    applyStimulus("beqT",     PCWE_COND,   PCSRC_BR,  32'h1000_FFFE, 32'h0,         1'b1, 32'h0000_1FFC, 1'b0);
    applyStimulus("hold",     PCWE_HOLD,   PCSRC_J,   32'h0C00_0040, 32'h0,         1'b1, 32'h0000_1FFC, 1'b0);
    applyStimulus("jrSet",    PCWE_UNCOND, PCSRC_JR,  32'h0,         32'h3000_0010, 1'b0, 32'h3000_0010, 1'b0);
    applyStimulus("jal",      PCWE_UNCOND, PCSRC_J,   32'h0C00_0040, 32'h0,         1'b0, 32'h3000_0100, 1'b0);
    applyStimulus("jrMis",    PCWE_UNCOND, PCSRC_JR,  32'h0,         32'h0000_0402, 1'b0, 32'h3000_0100, 1'b1);
    applyStimulus("jrAfter",  PCWE_UNCOND, PCSRC_JR,  32'h0,         32'h0000_0400, 1'b0, 32'h0000_0400, 1'b1);
    applyStimulus("ifAfter",  PCWE_UNCOND, PCSRC_SEQ, 32'h0,         32'h0,         1'b0, 32'h0000_0404, 1'b1);
    midReset("rst1");
    applyStimulus("rsvd",     PCWE_RSVD,   PCSRC_SEQ, 32'h0,         32'h0,         1'b0, 32'h0000_1000, 1'b1);
    midReset("rst2");
    applyStimulus("jrTop",    PCWE_UNCOND, PCSRC_JR,  32'h0,         32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0);
    applyStimulus("ifWrap",   PCWE_UNCOND, PCSRC_SEQ, 32'h0,         32'h0,         1'b0, 32'h0000_0000, 1'b0);
    for (int k = 1; k <= 15; k++)
      applyStimulus($sformatf("ifCnt%0d", k), PCWE_UNCOND, PCSRC_SEQ, 32'h0,
                    32'h0, 1'b0, 32'(4 * k), 1'b0);
    stimDone = 1'b1;
  end

  initial begin
    wait (stimDone);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL drain: actual %0d entries left required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
